alu_ctrl_seq: RTL and testbench

Registered, parametrised successor to the combinational ALU control decoder, placed at the ID/EX boundary of the pipelined MIPS core. Decodes `funct_i`/`ALUOp_i` into the team's ALU control code and registers it together with a valid bit. Flags unknown encodings. Sequences multi-cycle `mul` operations with a busy/ready handshake. Honours pipeline stall and flush.

---
 rtl/alu_ctrl_seq.sv | 148 ++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// ID/EX ALU control stage: registered funct/ALUOp decode with
// illegal flag, multi-cycle mul sequencing, stall and flush.
module alu_ctrl_seq #(
  parameter int CTRL_W     = 4,
  parameter int MUL_CYCLES = 4,
  parameter int ENABLE_MUL = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [5:0]        funct_i,
  input  logic [3:0]        ALUOp_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              ready_o,
  output logic [CTRL_W-1:0] ALUCtrl_o,
  output logic              valid_o,
  output logic              illegal_o,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(MUL_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [3:0] CODE_NOP = 4'd15;

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [3:0]       r_code;
  logic [3:0]       w_code_nx;
  logic             r_valid;
  logic             w_valid_nx;
  logic             r_ill;
  logic             w_ill_nx;
  logic [3:0]       w_dec_code;
  logic             w_dec_ill;
  logic             w_dec_mul;

  always_comb begin
    w_dec_code = CODE_NOP;
    w_dec_ill  = 1'b0;
    w_dec_mul  = 1'b0;
    if (ALUOp_i == 4'b1000) begin
      unique case (funct_i)
        6'b000000: w_dec_code = 4'd15;
        6'b100100: w_dec_code = 4'd0;
        6'b100101: w_dec_code = 4'd1;
        6'b100001: w_dec_code = 4'd2;
        6'b000111: w_dec_code = 4'd3;
        6'b000011: w_dec_code = 4'd4;
        6'b100011: w_dec_code = 4'd6;
        6'b100010: w_dec_code = 4'd6;
        6'b101010: w_dec_code = 4'd7;
        6'b011000: begin
          if (ENABLE_MUL != 0) begin
            w_dec_code = 4'd10;
            w_dec_mul  = 1'b1;
          end else begin
            w_dec_ill  = 1'b1;
          end
        end
        6'b001000: w_dec_code = 4'd11;
        6'b100000: w_dec_code = 4'd12;
        default:   w_dec_ill  = 1'b1;
      endcase
    end else begin
      unique case (ALUOp_i)
        4'b1001: w_dec_code = 4'd12;
        4'b1100: w_dec_code = 4'd5;
        4'b0001: w_dec_code = 4'd6;
        4'b0010: w_dec_code = 4'd6;
        4'b0011: w_dec_code = 4'd6;
        4'b0101: w_dec_code = 4'd7;
        4'b0111: w_dec_code = 4'd8;
        4'b0100: w_dec_code = 4'd9;
        default: w_dec_ill  = 1'b1;
      endcase
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_code_nx  = r_code;
    w_valid_nx = r_valid;
    w_ill_nx   = r_ill;
    if (flush_i) begin
      w_state_nx = IDLE;
      w_cnt_nx   = '0;
      w_code_nx  = CODE_NOP;
      w_valid_nx = 1'b0;
      w_ill_nx   = 1'b0;
    end else if (!stall_i) begin
      unique case (r_state)
        IDLE: begin
          if (valid_i) begin
            w_code_nx  = w_dec_code;
            w_valid_nx = 1'b1;
            w_ill_nx   = w_dec_ill;
            if (w_dec_mul && (MUL_CYCLES > 1)) begin
              w_state_nx = MUL;
              w_cnt_nx   = CNT_LOAD;
            end
          end else begin
            w_code_nx  = CODE_NOP;
            w_valid_nx = 1'b0;
            w_ill_nx   = 1'b0;
          end
        end
        MUL: begin
          // outputs hold; only the countdown moves
          w_cnt_nx = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) w_state_nx = IDLE;
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_code  <= CODE_NOP;
      r_valid <= 1'b0;
      r_ill   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_code  <= w_code_nx;
      r_valid <= w_valid_nx;
      r_ill   <= w_ill_nx;
    end
  end

  assign ready_o   = ~flush_i & ~stall_i & (r_state == IDLE);
  assign busy_o    = (r_state == MUL);
  assign ALUCtrl_o = CTRL_W'(r_code);
  assign valid_o   = r_valid;
  assign illegal_o = r_ill;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Randomized bench for alu_ctrl_seq: two instances (mul on,
// mul off with wide code) against a table-driven reference model.
module tb_alu_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid;
  logic [5:0] funct;
  logic [3:0] aluop;
  logic       stall;
  logic       flush;

  logic       a_ready, a_valid, a_ill, a_busy;
  logic [3:0] a_code;
  logic       b_ready, b_valid, b_ill, b_busy;
  logic [5:0] b_code;

  always #5 clk = ~clk;

  alu_ctrl_seq #(
    .CTRL_W(4), .MUL_CYCLES(4), .ENABLE_MUL(1)
  ) u_dut (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid),
    .funct_i(funct), .ALUOp_i(aluop),
    .stall_i(stall), .flush_i(flush),
    .ready_o(a_ready), .ALUCtrl_o(a_code),
    .valid_o(a_valid), .illegal_o(a_ill), .busy_o(a_busy)
  );

  alu_ctrl_seq #(
    .CTRL_W(6), .MUL_CYCLES(4), .ENABLE_MUL(0)
  ) u_dut_nm (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid),
    .funct_i(funct), .ALUOp_i(aluop),
    .stall_i(stall), .flush_i(flush),
    .ready_o(b_ready), .ALUCtrl_o(b_code),
    .valid_o(b_valid), .illegal_o(b_ill), .busy_o(b_busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  int rt_tab[bit [5:0]];
  int op_tab[bit [3:0]];
  int  P_N[2]  = '{4, 4};
  bit  P_EN[2] = '{1'b1, 1'b0};

  int  m_code[2];
  bit  m_valid[2];
  bit  m_ill[2];
  int  m_rem[2];

  bit  last_acc;
  int  t10;
  int  tbusy;
  int  busy_b_cnt = 0;

  function automatic void ref_dec(int d, bit [5:0] f, bit [3:0] op,
                                  output int code, output bit ill,
                                  output bit ismul);
    code  = 15;
    ill   = 1'b1;
    ismul = 1'b0;
    if (op == 4'b1000) begin
      if (rt_tab.exists(f)) begin
        code = rt_tab[f];
        ill  = 1'b0;
      end
      if (f == 6'b011000) begin
        ismul = P_EN[d];
        if (!P_EN[d]) begin
          code = 15;
          ill  = 1'b1;
        end
      end
    end else if (op_tab.exists(op)) begin
      code = op_tab[op];
      ill  = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_code[d]  = 15;
      m_valid[d] = 1'b0;
      m_ill[d]   = 1'b0;
      m_rem[d]   = 0;
    end
  endfunction

  function automatic void model_edge();
    int  c;
    bit  il;
    bit  mu;
    for (int d = 0; d < 2; d++) begin
      if (flush) begin
        m_valid[d] = 1'b0;
        m_ill[d]   = 1'b0;
        m_code[d]  = 15;
        m_rem[d]   = 0;
      end else if (!stall) begin
        if (m_rem[d] > 0) begin
          m_rem[d]--;
        end else if (valid) begin
          ref_dec(d, funct, aluop, c, il, mu);
          m_code[d]  = c;
          m_ill[d]   = il;
          m_valid[d] = 1'b1;
          m_rem[d]   = (mu && P_N[d] > 1) ? P_N[d] - 1 : 0;
        end else begin
          m_valid[d] = 1'b0;
          m_ill[d]   = 1'b0;
          m_code[d]  = 15;
        end
      end
    end
  endfunction

  task automatic check_all();
    bit exp_rdy;
    for (int d = 0; d < 2; d++) begin
      exp_rdy = !flush && !stall && (m_rem[d] == 0);
      chk($sformatf("d%0d.ready", d),
          d == 0 ? 32'(a_ready) : 32'(b_ready), 32'(exp_rdy));
      chk($sformatf("d%0d.code", d),
          d == 0 ? 32'(a_code) : 32'(b_code), 32'(m_code[d]));
      chk($sformatf("d%0d.valid", d),
          d == 0 ? 32'(a_valid) : 32'(b_valid), 32'(m_valid[d]));
      chk($sformatf("d%0d.illegal", d),
          d == 0 ? 32'(a_ill) : 32'(b_ill), 32'(m_ill[d]));
      chk($sformatf("d%0d.busy", d),
          d == 0 ? 32'(a_busy) : 32'(b_busy), 32'(m_rem[d] > 0));
    end
  endtask

  task automatic step(bit v, bit [5:0] f, bit [3:0] op,
                      bit s = 1'b0, bit fl = 1'b0);
    @(negedge clk);
    valid = v;
    funct = f;
    aluop = op;
    stall = s;
    flush = fl;
    #1;
    check_all();
    if (a_valid && a_code == 4'd10) t10++;
    if (a_busy) tbusy++;
    if (b_busy) busy_b_cnt++;
    @(posedge clk);
    last_acc = v && !fl && !s && (m_rem[0] == 0);
    model_edge();
  endtask

  task automatic mul_then_add(bit with_stall);
    int k;
    t10   = 0;
    tbusy = 0;
    step(1'b1, 6'b011000, 4'b1000);
    k = 0;
    do begin
      step(1'b1, 6'b100000, 4'b1000,
           with_stall && (k == 1 || k == 2));
      k++;
    end while (!last_acc && k < 20);
    chk("mul.add_accepted", 32'(last_acc), 32'd1);
    step(1'b0, 6'd0, 4'd0);
    chk("mul.code10_cycles", 32'(t10), with_stall ? 32'd6 : 32'd4);
    chk("mul.busy_cycles", 32'(tbusy), with_stall ? 32'd5 : 32'd3);
  endtask

  bit [5:0] legal_f[12] = '{6'b000000, 6'b100100, 6'b100101,
                            6'b100001, 6'b000111, 6'b000011,
                            6'b100011, 6'b100010, 6'b101010,
                            6'b011000, 6'b001000, 6'b100000};

  initial begin
    bit       pv;
    bit [5:0] pf;
    bit [3:0] po;

    rt_tab[6'b000000] = 15; rt_tab[6'b100100] = 0;
    rt_tab[6'b100101] = 1;  rt_tab[6'b100001] = 2;
    rt_tab[6'b000111] = 3;  rt_tab[6'b000011] = 4;
    rt_tab[6'b100011] = 6;  rt_tab[6'b100010] = 6;
    rt_tab[6'b101010] = 7;  rt_tab[6'b011000] = 10;
    rt_tab[6'b001000] = 11; rt_tab[6'b100000] = 12;
    op_tab[4'b1001] = 12; op_tab[4'b1100] = 5;
    op_tab[4'b0010] = 6;  op_tab[4'b0011] = 6;
    op_tab[4'b0001] = 6;  op_tab[4'b0101] = 7;
    op_tab[4'b0111] = 8;  op_tab[4'b0100] = 9;

    rst_n = 1'b0;
    valid = 1'b0;
    funct = '0;
    aluop = '0;
    stall = 1'b0;
    flush = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst.code", 32'(a_code), 32'd15);
    chk("rst.valid", 32'(a_valid), 32'd0);
    chk("rst.busy", 32'(a_busy), 32'd0);
    chk("rst.ready", 32'(a_ready), 32'd1);
    chk("rst.code_wide", 32'(b_code), 32'd15);

    step(1'b1, 6'b100100, 4'b1000);
    step(1'b1, 6'b101010, 4'b1000);
    step(1'b1, 6'b100000, 4'b1000);
    step(1'b1, 6'b000000, 4'b1100);
    step(1'b1, 6'b010101, 4'b1000);
    step(1'b0, 6'd0, 4'd0);

    mul_then_add(1'b0);
    mul_then_add(1'b1);

    step(1'b1, 6'b011000, 4'b1000);
    step(1'b0, 6'd0, 4'd0);
    step(1'b0, 6'd0, 4'd0, 1'b0, 1'b1);
    step(1'b1, 6'd0, 4'b1001);
    step(1'b0, 6'd0, 4'd0);

    pv = 1'b0;
    pf = '0;
    po = '0;
    last_acc = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        step(1'b1, 6'b011000, 4'b1000);
        @(negedge clk);
        valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.code", 32'(a_code), 32'd15);
        chk("arst.valid", 32'(a_valid), 32'd0);
        chk("arst.illegal", 32'(a_ill), 32'd0);
        chk("arst.busy", 32'(a_busy), 32'd0);
        chk("arst.code_wide", 32'(b_code), 32'd15);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        last_acc = 1'b1;
      end
      if (!pv || last_acc) begin
        pv = ($urandom_range(0, 3) != 0);
        po = ($urandom_range(0, 1) == 0) ? 4'b1000
             : 4'($urandom_range(0, 15));
        pf = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
             : legal_f[$urandom_range(0, 11)];
      end
      step(pv, pf, po,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 11) == 0);
    end

    chk("nm.busy_never", 32'(busy_b_cnt), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
